// File: rtl/bus_arbiter_ctrl_if.sv
// bus_arbiter_ctrl_if: requester inputs and shared-bus outputs of the 4-source arbiter.
interface bus_arbiter_ctrl_if #(parameter int DATA_W = 8);
  logic [3:0] req;
  logic [3:0] last;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] d3;
  logic rr_mode;
  logic bus_ready;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic busy;
  logic bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic bus_last;
  logic timeout_err;
  modport master (
    input req, last, d0, d1, d2, d3, rr_mode, bus_ready,
    output gnt, gnt_id, busy, bus_valid, bus_data, bus_last, timeout_err
  );
  modport slave (
    output req, last, d0, d1, d2, d3, rr_mode, bus_ready,
    input gnt, gnt_id, busy, bus_valid, bus_data, bus_last, timeout_err
  );
endinterface

// File: rtl/bus_arbiter_ctrl.sv
// bus_arbiter_ctrl: burst-holding 4-source arbiter with fixed/round-robin selection and beat watchdog.
module bus_arbiter_ctrl #(
  parameter int DATA_W = 8,
  parameter int MAX_BEATS = 16
) (
  input logic clk,
  input logic rst_n,
  bus_arbiter_ctrl_if.master bus
);
  localparam int CW = $clog2(MAX_BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [3:0] gnt_q, gnt_d, rot;
  logic [1:0] gnt_id_q, gnt_id_d, rr_ptr_q, rr_ptr_d, hi, f, w;
  logic busy_q, busy_d, timeout_q, timeout_d, accept, rel;
  logic [CW-1:0] beat_q, beat_d;
  // rotating by rr_ptr turns the round-robin search into a lowest-set-bit pick
  assign rot = 4'({bus.req, bus.req} >> rr_ptr_q);
  assign f = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign hi = bus.req[3] ? 2'd3 : bus.req[2] ? 2'd2 : bus.req[1] ? 2'd1 : 2'd0;
  assign w = bus.rr_mode ? rr_ptr_q + f : hi;
  assign bus.gnt = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy = busy_q;
  assign bus.timeout_err = timeout_q;
  assign bus.bus_valid = busy_q & bus.req[gnt_id_q];
  assign bus.bus_last = busy_q & (bus.last[gnt_id_q] | beat_q == LAST_BEAT);
  assign bus.bus_data = !busy_q ? '0 :
                        gnt_id_q == 2'd3 ? bus.d3 :
                        gnt_id_q == 2'd2 ? bus.d2 :
                        gnt_id_q == 2'd1 ? bus.d1 : bus.d0;
  assign accept = bus.bus_valid & bus.bus_ready;
  assign rel = accept & bus.bus_last;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d = busy_q;
    rr_ptr_d = rr_ptr_q;
    beat_d = beat_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (|bus.req) begin
        state_d = GRANT;
        gnt_d = 4'b0001 << w;
        gnt_id_d = w;
        busy_d = 1'b1;
        beat_d = '0;
      end
    end else if (accept) begin
      beat_d = rel ? '0 : beat_q + CW'(1);
      if (rel) begin
        state_d = IDLE;
        gnt_d = '0;
        busy_d = 1'b0;
        rr_ptr_d = gnt_id_q + 2'd1;
        timeout_d = ~bus.last[gnt_id_q];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      gnt_id_q <= '0;
      busy_q <= 1'b0;
      rr_ptr_q <= '0;
      beat_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q <= beat_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// tb_bus_arbiter_ctrl: directed checks of arbitration, stalls, watchdog and reset with MAX_BEATS=4.
module tb_bus_arbiter_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bus_arbiter_ctrl_if #(.DATA_W(8)) bif ();
  bus_arbiter_ctrl #(.DATA_W(8), .MAX_BEATS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic drv(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    bif.req = r;
    bif.last = l;
    bif.bus_ready = rdy;
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bif.d0 = 8'hA0;
    bif.d1 = 8'hB1;
    bif.d2 = 8'hC2;
    bif.d3 = 8'hD3;
    bif.rr_mode = 1'b0;
    drv(4'b0000, 4'b0000, 1'b0);
    tick;
    tick;
    chk("rst_gnt", bif.gnt, 0);
    chk("rst_gnt_id", bif.gnt_id, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_valid", bif.bus_valid, 0);
    chk("rst_data", bif.bus_data, 0);
    chk("rst_last", bif.bus_last, 0);
    chk("rst_tmo", bif.timeout_err, 0);
    rst_n = 1'b1;
    // fixed priority: 3, then 1, then 0 with idle turnarounds
    drv(4'b1011, 4'b1111, 1'b1);
    chk("fx_idle0", bif.busy, 0);
    tick;
    chk("fx_gnt3", bif.gnt, 4'b1000);
    chk("fx_id3", bif.gnt_id, 3);
    chk("fx_data3", bif.bus_data, 8'hD3);
    chk("fx_valid3", bif.bus_valid, 1);
    chk("fx_last3", bif.bus_last, 1);
    tick;
    drv(4'b0011, 4'b1111, 1'b1);
    chk("fx_turn1", bif.gnt, 0);
    chk("fx_turn1_valid", bif.bus_valid, 0);
    tick;
    chk("fx_gnt1", bif.gnt, 4'b0010);
    chk("fx_data1", bif.bus_data, 8'hB1);
    tick;
    drv(4'b0001, 4'b1111, 1'b1);
    chk("fx_turn2", bif.busy, 0);
    chk("fx_id_hold", bif.gnt_id, 1);
    tick;
    chk("fx_gnt0", bif.gnt, 4'b0001);
    chk("fx_data0", bif.bus_data, 8'hA0);
    tick;
    drv(4'b0000, 4'b0000, 1'b1);
    chk("fx_end", bif.gnt, 0);
    // stall and hold: src2 3-beat burst, ready 1,0,0,1,1, src3 waiting
    drv(4'b0100, 4'b0000, 1'b1);
    tick;
    drv(4'b1100, 4'b0000, 1'b1);
    chk("st_gnt2", bif.gnt, 4'b0100);
    chk("st_b1_last", bif.bus_last, 0);
    tick;
    drv(4'b1100, 4'b0000, 1'b0);
    chk("st_stall1", bif.gnt, 4'b0100);
    chk("st_stall1_valid", bif.bus_valid, 1);
    tick;
    chk("st_stall2", bif.gnt, 4'b0100);
    tick;
    drv(4'b1100, 4'b0000, 1'b1);
    chk("st_b2_last", bif.bus_last, 0);
    chk("st_b2_data", bif.bus_data, 8'hC2);
    tick;
    drv(4'b1100, 4'b0100, 1'b1);
    chk("st_b3_last", bif.bus_last, 1);
    chk("st_nopreempt", bif.gnt, 4'b0100);
    tick;
    drv(4'b1000, 4'b1000, 1'b1);
    chk("st_turn", bif.gnt, 0);
    chk("st_turn_tmo", bif.timeout_err, 0);
    tick;
    chk("st_gnt3", bif.gnt, 4'b1000);
    tick;
    drv(4'b0000, 4'b0000, 1'b1);
    chk("st_end", bif.busy, 0);
    // watchdog: src1 never asserts last
    drv(4'b0010, 4'b0000, 1'b1);
    tick;
    chk("wd_gnt1", bif.gnt, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      chk("wd_last_early", bif.bus_last, 0);
      tick;
    end
    chk("wd_last_forced", bif.bus_last, 1);
    chk("wd_tmo_pre", bif.timeout_err, 0);
    tick;
    drv(4'b0000, 4'b0000, 1'b1);
    chk("wd_release", bif.gnt, 0);
    chk("wd_tmo", bif.timeout_err, 1);
    tick;
    chk("wd_tmo_once", bif.timeout_err, 0);
    // owner drops req for 2 cycles mid-burst
    drv(4'b0010, 4'b0000, 1'b1);
    tick;
    chk("dr_gnt", bif.gnt, 4'b0010);
    tick;
    drv(4'b0000, 4'b0000, 1'b1);
    chk("dr_valid0", bif.bus_valid, 0);
    chk("dr_hold0", bif.gnt, 4'b0010);
    tick;
    chk("dr_valid1", bif.bus_valid, 0);
    chk("dr_hold1", bif.gnt, 4'b0010);
    tick;
    drv(4'b0010, 4'b0000, 1'b1);
    chk("dr_resume", bif.bus_valid, 1);
    chk("dr_cnt1", bif.bus_last, 0);
    tick;
    chk("dr_cnt2", bif.bus_last, 0);
    tick;
    chk("dr_cnt3", bif.bus_last, 1);
    tick;
    drv(4'b0000, 4'b0000, 1'b1);
    chk("dr_release", bif.busy, 0);
    tick;
    // asynchronous reset mid-burst
    drv(4'b0100, 4'b0000, 1'b0);
    tick;
    chk("ar_gnt_pre", bif.gnt, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", bif.gnt, 0);
    chk("ar_busy", bif.busy, 0);
    chk("ar_valid", bif.bus_valid, 0);
    drv(4'b0000, 4'b0000, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("ar_post_gnt", bif.gnt, 0);
    chk("ar_post_busy", bif.busy, 0);
    chk("ar_post_tmo", bif.timeout_err, 0);
    // round robin from rr_ptr=0, wrapping 3 -> 0
    bif.rr_mode = 1'b1;
    drv(4'b1111, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_gnt", bif.gnt, 32'(4'b0001 << (i % 4)));
      chk("rr_id", bif.gnt_id, i % 4);
      tick;
      chk("rr_turn", bif.busy, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
